// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that owns a single-port 16x8 synchronous RAM; reads take priority over writes.
// Optional flush port and logic are enabled by defining RAM_FIFO_FLUSH_EN.
module ram_fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_t;

    rd_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]     mem_count_q, mem_count_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                flush_s;
    logic                rd_pend_s;
    logic                rd_issue_s;
    logic                wr_accept_s;

`ifdef RAM_FIFO_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // A read may only issue when the output register will be free by the time its data lands.
    assign rd_issue_s  = (mem_count_q != {(ADDR_W+1){1'b0}}) && !rd_pend_s
                         && (!out_valid_q || out_ready) && !flush_s;
    assign in_ready    = rst_n && (mem_count_q < DEPTH_C) && !rd_issue_s && !flush_s;
    assign wr_accept_s = in_valid && in_ready;

    assign count = mem_count_q + {{ADDR_W{1'b0}}, rd_pend_s} + {{ADDR_W{1'b0}}, out_valid_q};
    assign full  = (mem_count_q == DEPTH_C);
    assign empty = (count == {(ADDR_W+1){1'b0}});
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush_s) begin
            state_d = RD_IDLE;
        end else begin
            case (state_q)
                RD_IDLE: state_d = rd_issue_s ? RD_WAIT : RD_IDLE;
                RD_WAIT: state_d = RD_IDLE;
                default: state_d = RD_IDLE;
            endcase
        end
    end

    // Read FSM outputs.
    always_comb begin
        rd_pend_s = 1'b0;
        case (state_q)
            RD_IDLE: rd_pend_s = 1'b0;
            RD_WAIT: rd_pend_s = 1'b1;
            default: rd_pend_s = 1'b0;
        endcase
    end

    // Single RAM port mux: read address, write address, or park on rptr.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = rptr_q;
        ram_din  = in_data;
        if (rd_issue_s) begin
            ram_we   = 1'b0;
            ram_addr = rptr_q;
        end else if (wr_accept_s) begin
            ram_we   = 1'b1;
            ram_addr = wptr_q;
        end else begin
            ram_we   = 1'b0;
            ram_addr = rptr_q;
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_count_d = mem_count_q;
        if (flush_s) begin
            wptr_d      = {ADDR_W{1'b0}};
            rptr_d      = {ADDR_W{1'b0}};
            mem_count_d = {(ADDR_W+1){1'b0}};
        end else if (rd_issue_s) begin
            rptr_d      = rptr_q + PTR_ONE;
            mem_count_d = mem_count_q - CNT_ONE;
        end else if (wr_accept_s) begin
            wptr_d      = wptr_q + PTR_ONE;
            mem_count_d = mem_count_q + CNT_ONE;
        end else begin
            mem_count_d = mem_count_q;
        end
    end

    // Output register: RAM data lands the cycle after issue and holds until taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush_s) begin
            out_valid_d = 1'b0;
        end else if (rd_pend_s) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_dout;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= {ADDR_W{1'b0}};
            rptr_q      <= {ADDR_W{1'b0}};
            mem_count_q <= {(ADDR_W+1){1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_count_q <= mem_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 16x8 synchronous RAM.
// Flush sequence is exercised only when RAM_FIFO_FLUSH_EN is defined.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
`ifdef RAM_FIFO_FLUSH_EN
    logic       flush;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [16];

    always #5 clk = ~clk;

    // Sync_RAM model: registered read, write on we.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    ram_fifo_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef RAM_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .full(full),
        .empty(empty),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [4:0] e_cnt;
        logic       e_full;
        logic       e_empty;
        logic       e_we;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("push_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input int n, input logic [7:0] first, input string nm);
        int got = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && got < n; k++) begin
            #1;
            if (out_valid) begin
                chk(nm, {24'd0, out_data}, {24'd0, first + 8'(got)});
                got++;
            end
            tick();
        end
        chk({nm, "_cnt"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int wi;
        int ri;
        bit acc;

        // Basic order and arbitration: hand-traced cycle by cycle from an empty FIFO.
        vecs[0] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef RAM_FIFO_FLUSH_EN
        flush     = 1'b0;
`endif
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data}, 32'd0);
        chk("rst_count",     {27'd0, count}, 32'd0);
        chk("rst_empty",     {31'd0, empty}, 32'd1);
        chk("rst_full",      {31'd0, full}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            #1;
            chk("vec_in_ready",  {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            chk("vec_out_valid", {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) chk("vec_out_data", {24'd0, out_data}, {24'd0, vecs[i].e_od});
            chk("vec_count",     {27'd0, count}, {27'd0, vecs[i].e_cnt});
            chk("vec_full",      {31'd0, full}, {31'd0, vecs[i].e_full});
            chk("vec_empty",     {31'd0, empty}, {31'd0, vecs[i].e_empty});
            chk("vec_ram_we",    {31'd0, ram_we}, {31'd0, vecs[i].e_we});
            tick();
        end
        in_valid = 1'b0;

        // Fill to DEPTH+1 words with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
        tick();
        tick();
        chk("fill_count",     {27'd0, count}, 32'd17);
        chk("fill_full",      {31'd0, full}, 32'd1);
        chk("fill_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_out_data",  {24'd0, out_data}, 32'h10);
        out_ready = 1'b1;
        #1;
        chk("fill_full_pre",  {31'd0, full}, 32'd1);
        chk("fill_rd_we",     {31'd0, ram_we}, 32'd0);
        tick();
        chk("fill_full_drop", {31'd0, full}, 32'd0);
        drain(16, 8'h11, "fill_drain");
        chk("fill_empty",     {31'd0, empty}, 32'd1);

        // Wrap: streaming 40 words through a 16-entry RAM.
        wi = 0;
        ri = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 400 && ri < 40; k++) begin
            in_valid = (wi < 40);
            in_data  = 8'(wi);
            #1;
            if (in_valid) chk("wrap_we_eq_ready", {31'd0, ram_we}, {31'd0, in_ready});
            if (out_valid) begin
                chk("wrap_data", {24'd0, out_data}, ri);
                ri++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) wi++;
        end
        in_valid = 1'b0;
        chk("wrap_total", ri, 40);
        #1;
        chk("wrap_count", {27'd0, count}, 32'd0);
        chk("wrap_empty", {31'd0, empty}, 32'd1);
        tick();

        // Reset mid-operation: stale RAM contents must never surface.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h01 + 8'(i));
        tick();
        tick();
        chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_count",     {27'd0, count}, 32'd5);
        in_valid = 1'b1;
        in_data  = 8'h99;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov",    {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_we",    {31'd0, ram_we}, 32'd0);
        chk("mid_rst_od",    {24'd0, out_data}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        push(8'h3C);
        drain(1, 8'h3C, "mid_post");
        chk("mid_empty", {31'd0, empty}, 32'd1);

`ifdef RAM_FIFO_FLUSH_EN
        // Flush while a RAM read is in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
        tick();
        tick();
        chk("fl_pre_count", {27'd0, count}, 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_ram_we",   {31'd0, ram_we}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", {27'd0, count}, 32'd0);
        chk("fl_ov",    {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        chk("fl_ov_late", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        push(8'h77);
        drain(1, 8'h77, "fl_post");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of the single-port synchronous RAM (Sync_RAM, 16x8) and owns its we/addr/din/dout ports.
- Accepts a valid/ready write stream, stores words in the RAM and returns them in order on a valid/ready read stream.
- Arbitrates the single RAM port between writes and reads and manages the RAM's one-cycle read latency.

Parameters:
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W words (16), no separate depth parameter.
DATA_W, 8, word width; matches RAM din/dout.

Ports:
clk  input  1  rising-edge clock, shared with the RAM.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  write-side data valid.
in_ready  output  1  write-side ready; word accepted when in_valid && in_ready.
in_data  input  DATA_W  write-side data.
out_valid  output  1  read-side data valid (registered).
out_ready  input  1  read-side consumer ready.
out_data  output  DATA_W  read-side data (registered).
count  output  ADDR_W+1  total occupancy = mem_count + rd_pend + out_valid, range 0..DEPTH+1.
full  output  1  mem_count == DEPTH.
empty  output  1  count == 0.
ram_we  output  1  to RAM we.
ram_addr  output  ADDR_W  to RAM addr.
ram_din  output  DATA_W  to RAM din.
ram_dout  input  DATA_W  from RAM dout; valid the cycle after a read address is presented.

Behaviour:
- Reset (rst_n low, asynchronous): wptr=0, rptr=0, mem_count=0, rd_pend=0, out_valid=0, out_data=0.
  - in_ready and ram_we are gated to 0 while rst_n is low.
  - RAM contents are not cleared; they are discarded by the pointer reset.
- Read FSM, 2 states:
  - RD_IDLE -> RD_WAIT on rd_issue.
  - RD_WAIT -> RD_IDLE unconditionally next cycle; on that edge out_data <= ram_dout and out_valid <= 1.
  - rd_pend = (state == RD_WAIT).
- rd_issue = (mem_count != 0) && !rd_pend && (!out_valid || out_ready).
  - When asserted: ram_we=0, ram_addr=rptr; at the edge rptr++ and mem_count--.
- Write: in_ready = rst_n && (mem_count < DEPTH) && !rd_issue. Reads have priority over writes.
  - On accept: ram_we=1, ram_addr=wptr, ram_din=in_data; at the edge wptr++ and mem_count++.
- When neither a read nor a write is active: ram_we=0, ram_addr=rptr.
- Pointers wrap modulo DEPTH (15 -> 0). mem_count has ADDR_W+1 bits.
- At most one RAM access per cycle; read issue and write accept never coincide.
- out_valid clears on out_ready && out_valid unless new data lands the same edge.
  - Once asserted, out_valid and out_data stay stable until the word is taken.
- Latencies:
  - Accept into an empty FIFO -> out_valid 3 cycles later.
  - Read issue -> out_valid 2 cycles later.
  - Sustained read throughput is 1 word per 2 cycles.
- in_ready depends combinationally on out_ready through rd_issue. This path is accepted.
- Capacity is DEPTH+1 words: 16 in RAM plus 1 in the output register.
- full=1 blocks writes. Reads proceed regardless of in_valid.

Optional Feature:
RAM_FIFO_FLUSH_EN:
- Defined: adds input port flush (1 bit). flush=1 at an edge sets wptr, rptr, mem_count, out_valid and state to reset values; any returning read data is discarded.
  - in_ready=0 and ram_we=0 during a flush cycle.
  - flush has priority over all other activity.
- Undefined: the port and logic are absent; contents are cleared only by rst_n.

Test Plan:
- Basic order: push 0xAA then 0x55, out_ready=1 -> out_data 0xAA then 0x55; first out_valid 3 cycles after the 0xAA accept; count returns to 0; empty=1.
- Fill: out_ready=0, push 0x10..0x20 (17 words) -> all 17 accepted, count=17, full=1, in_ready=0, out_data=0x10. Then out_ready=1 -> 0x10..0x20 drained in order; full drops after the first RAM read.
- Wrap: in_valid held, out_ready=1, stream 0x00..0x27 (40 words) -> output order identical, pointers wrap twice, no loss or duplication. in_ready must be 0 exactly in rd_issue cycles (check ram_we=0 there).
- Arbitration: with mem_count>0, output register empty and in_valid=1 -> the read issues, in_ready=0 that cycle, and the write is accepted the next cycle.
- Reset mid-op: 5 words stored and out_valid=1, pulse rst_n low between edges -> outputs clear immediately, count=0. Then push 0x3C -> out_data 0x3C (stale data never appears).
- Flush (RAM_FIFO_FLUSH_EN): 4 words queued with a read in RAM_FIFO's RD_WAIT, assert flush for 1 cycle -> count=0 next cycle, no out_valid from the discarded read, and a subsequent push of 0x77 returns 0x77.
